pocket_event_encoder: RTL and testbench

//  Producer side of the score interface: turns per-pixel ball/hole collision flags from the VGA

---
 rtl/pocket_pkg.sv | 26 ++
 rtl/pocket_event_encoder_picker.sv | 41 ++++
 rtl/pocket_event_encoder.sv | 178 +++++++++++++++++
 tb/tb_pocket_event_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pocket_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pocket_pkg
// Purpose : Shared constants and types for the pocket event encoder.
//           Ball count default, white-ball index, FSM state encoding and
//           sound-select codes.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pocket_pkg;

  localparam int NUM_BALLS_DEF = 8;
  localparam int WHITE_IDX     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pocket_state_t;

  localparam logic [1:0] SND_COLOUR = 2'd1;
  localparam logic [1:0] SND_WHITE  = 2'd2;
  localparam logic [1:0] SND_WIN    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pocket_event_encoder_picker.sv
`default_nettype none
// ============================================================================
// Module  : pocket_priority_picker
// Purpose : Combinational arbiter over the pending-event mask. Coloured
//           balls win over white; among coloured balls the lowest index wins.
// Ports   : pending  in  NUM_BALLS  pending-event mask
//           valid    out 1          any bit of pending set
//           grant    out NUM_BALLS  one-hot selected ball (0 when !valid)
//           is_white out 1          the selected ball is the white ball
// Rev     : 1.0  initial release
// ============================================================================
module pocket_priority_picker
  import pocket_pkg::*;
#(
  parameter int NUM_BALLS = NUM_BALLS_DEF
) (
  input  logic [NUM_BALLS-1:0] pending,
  output logic                 valid,
  output logic [NUM_BALLS-1:0] grant,
  output logic                 is_white
);

  always_comb begin
    grant    = '0;
    valid    = |pending;
    // White only when no coloured ball is waiting.
    is_white = (pending[NUM_BALLS-1:1] == '0) && pending[WHITE_IDX];
    // Scan downwards so the lowest pending coloured index is the last write.
    for (int i = NUM_BALLS - 1; i >= 1; i--) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    if (is_white) begin
      grant[WHITE_IDX] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pocket_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : pocket_event_encoder
// Purpose : Converts per-pixel ball/hole collision flags into serialized
//           one-cycle increaseScore / decreaseScore pulses. Coloured balls
//           score once per game; the white ball penalizes once per episode
//           of consecutive hit frames. Exports the sunk-ball mask.
// Macro   : POCKET_SOUND_EN adds soundReq/soundSel outputs.
// Ports   : clk, resetN (async, active low), startOfFrame, newGame,
//           ballHoleHit[NUM_BALLS], increaseScore, decreaseScore,
//           ballSunk[NUM_BALLS], allSunk, busy
//           [POCKET_SOUND_EN] soundReq, soundSel[2]
// Rev     : 1.0  initial release
// ============================================================================
module pocket_event_encoder
  import pocket_pkg::*;
#(
  parameter int NUM_BALLS = NUM_BALLS_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 newGame,
  input  logic [NUM_BALLS-1:0] ballHoleHit,
  output logic                 increaseScore,
  output logic                 decreaseScore,
  output logic [NUM_BALLS-1:0] ballSunk,
  output logic                 allSunk,
`ifdef POCKET_SOUND_EN
  output logic                 soundReq,
  output logic [1:0]           soundSel,
`endif
  output logic                 busy
);

  pocket_state_t        state_q, state_d;
  logic [NUM_BALLS-1:0] frame_hit_q, frame_hit_d;
  logic [NUM_BALLS-1:0] pending_q, pending_d;
  logic [NUM_BALLS-1:0] sunk_q, sunk_d;
  logic                 prev_hit0_q, prev_hit0_d;
  logic                 inc_q, inc_d;
  logic                 dec_q, dec_d;
  logic                 all_sunk_q, all_sunk_d;

  logic [NUM_BALLS-1:0] commit;
  logic [NUM_BALLS-1:0] clr;
  logic                 take;
  logic                 pick_valid;
  logic [NUM_BALLS-1:0] pick_grant;
  logic                 pick_white;

  pocket_priority_picker #(
    .NUM_BALLS (NUM_BALLS)
  ) u_picker (
    .pending  (pending_q),
    .valid    (pick_valid),
    .grant    (pick_grant),
    .is_white (pick_white)
  );

`ifdef POCKET_SOUND_EN
  logic       snd_req_q, snd_req_d;
  logic [1:0] snd_sel_q, snd_sel_d;
  logic       last_colour;
`endif

  always_comb begin
    state_d     = state_q;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    clr         = '0;
    commit      = '0;

    // Commit the finished frame; the SOF-cycle hits start the new frame.
    if (startOfFrame) begin
      commit            = frame_hit_q & ~sunk_q;
      commit[WHITE_IDX] = frame_hit_q[WHITE_IDX] & ~prev_hit0_q;
    end
    frame_hit_d = startOfFrame ? ballHoleHit : (frame_hit_q | ballHoleHit);
    prev_hit0_d = startOfFrame ? frame_hit_q[WHITE_IDX] : prev_hit0_q;
    sunk_d      = sunk_q | {commit[NUM_BALLS-1:1], 1'b0};

    // The gap cycle doubles as the arbitration slot, so back-to-back
    // events come out two cycles apart.
    take = pick_valid && (state_q != PULSE);

    case (state_q)
      IDLE:    state_d = pick_valid ? PULSE : IDLE;
      PULSE:   state_d = GAP;
      GAP:     state_d = pick_valid ? PULSE : IDLE;
      default: state_d = IDLE;
    endcase

    if (take) begin
      inc_d = ~pick_white;
      dec_d = pick_white;
      clr   = pick_grant;
    end

    // Clear first, then OR in commits so a same-cycle re-arm survives.
    pending_d  = (pending_q & ~clr) | commit;
    all_sunk_d = &sunk_d[NUM_BALLS-1:1];

    if (newGame) begin
      state_d     = IDLE;
      frame_hit_d = '0;
      prev_hit0_d = 1'b0;
      pending_d   = '0;
      sunk_d      = '0;
      inc_d       = 1'b0;
      dec_d       = 1'b0;
      all_sunk_d  = 1'b0;
    end
  end

`ifdef POCKET_SOUND_EN
  always_comb begin
    snd_req_d   = 1'b0;
    snd_sel_d   = 2'd0;
    // Winning pulse: every coloured ball sunk and this is the last one queued.
    last_colour = (&sunk_q[NUM_BALLS-1:1]) &&
                  ((pending_q[NUM_BALLS-1:1] & ~pick_grant[NUM_BALLS-1:1]) == '0);
    if (take && !newGame) begin
      snd_req_d = 1'b1;
      if (pick_white) begin
        snd_sel_d = SND_WHITE;
      end else if (last_colour) begin
        snd_sel_d = SND_WIN;
      end else begin
        snd_sel_d = SND_COLOUR;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      snd_req_q <= 1'b0;
      snd_sel_q <= 2'd0;
    end else begin
      snd_req_q <= snd_req_d;
      snd_sel_q <= snd_sel_d;
    end
  end

  assign soundReq = snd_req_q;
  assign soundSel = snd_sel_q;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      frame_hit_q <= '0;
      pending_q   <= '0;
      sunk_q      <= '0;
      prev_hit0_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      all_sunk_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_hit_q <= frame_hit_d;
      pending_q   <= pending_d;
      sunk_q      <= sunk_d;
      prev_hit0_q <= prev_hit0_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      all_sunk_q  <= all_sunk_d;
    end
  end

  assign increaseScore = inc_q;
  assign decreaseScore = dec_q;
  assign ballSunk      = sunk_q;
  assign allSunk       = all_sunk_q;
  assign busy          = (pending_q != '0) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pocket_event_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_pocket_event_encoder
// Purpose : Self-checking bench for pocket_event_encoder (NUM_BALLS = 8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_pocket_event_encoder;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       newGame = 1'b0;
  logic [7:0] ballHoleHit = 8'h00;
  logic       increaseScore;
  logic       decreaseScore;
  logic [7:0] ballSunk;
  logic       allSunk;
  logic       busy;
`ifdef POCKET_SOUND_EN
  logic       soundReq;
  logic [1:0] soundSel;
`endif

  pocket_event_encoder #(.NUM_BALLS(8)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .newGame       (newGame),
    .ballHoleHit   (ballHoleHit),
    .increaseScore (increaseScore),
    .decreaseScore (decreaseScore),
    .ballSunk      (ballSunk),
    .allSunk       (allSunk),
`ifdef POCKET_SOUND_EN
    .soundReq      (soundReq),
    .soundSel      (soundSel),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (increaseScore === 1'b1 && decreaseScore === 1'b1) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hits for npix cycles, then one SOF cycle with no hits; returns in cycle N+1.
  task automatic frame(input logic [7:0] hits, input int npix);
    ballHoleHit = hits;
    repeat (npix) tick();
    ballHoleHit  = 8'h00;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // Starts in cycle N+1; first = offset from N of the first pulse, -1 if none.
  task automatic count_pulses(input int ncyc, output int ni, output int nd, output int first);
    ni = 0; nd = 0; first = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (increaseScore === 1'b1 || decreaseScore === 1'b1) begin
        if (first < 0) first = k + 1;
      end
      if (increaseScore === 1'b1) ni++;
      if (decreaseScore === 1'b1) nd++;
      tick();
    end
  endtask

  task automatic new_game();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
  endtask

  typedef struct {
    logic [7:0] hits;
    int         exp_inc;
    int         exp_dec;
    logic [7:0] exp_sunk;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int ni, nd, first, dec_total;
    logic       inc_log  [1:9];
    logic       dec_log  [1:9];
    logic       busy_log [1:9];
    logic [1:0] snd_log  [1:9];

    vecs[0] = '{8'h00, 0, 0, 8'h00};
    vecs[1] = '{8'h08, 1, 0, 8'h08};
    vecs[2] = '{8'h08, 0, 0, 8'h08};
    vecs[3] = '{8'h25, 2, 1, 8'h2C};
    vecs[4] = '{8'h01, 0, 0, 8'h2C};
    vecs[5] = '{8'h00, 0, 0, 8'h2C};
    vecs[6] = '{8'h01, 0, 1, 8'h2C};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_inc",  increaseScore, 0);
    check("rst_dec",  decreaseScore, 0);
    check("rst_sunk", ballSunk, 0);
    check("rst_all",  allSunk, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();

    // Table-driven frames within one game
    for (int v = 0; v < 7; v++) begin
      frame(vecs[v].hits, 5);
      count_pulses(12, ni, nd, first);
      check($sformatf("vec%0d_inc", v), ni, vecs[v].exp_inc);
      check($sformatf("vec%0d_dec", v), nd, vecs[v].exp_dec);
      check($sformatf("vec%0d_sunk", v), ballSunk, vecs[v].exp_sunk);
      check($sformatf("vec%0d_first", v), first,
            (vecs[v].exp_inc + vecs[v].exp_dec > 0) ? 2 : -1);
    end

    // Balls 2, 5 and white in one frame: exact cycle positions
    new_game();
    check("ng_sunk", ballSunk, 0);
    frame(8'h25, 40);
    for (int k = 1; k <= 9; k++) begin
      inc_log[k]  = increaseScore;
      dec_log[k]  = decreaseScore;
      busy_log[k] = busy;
`ifdef POCKET_SOUND_EN
      snd_log[k]  = soundSel;
`else
      snd_log[k]  = 2'd0;
`endif
      tick();
    end
    check("seq_inc_n2", inc_log[2], 1);
    check("seq_inc_n3", inc_log[3], 0);
    check("seq_inc_n4", inc_log[4], 1);
    check("seq_dec_n4", dec_log[4], 0);
    check("seq_dec_n6", dec_log[6], 1);
    check("seq_inc_n6", inc_log[6], 0);
    check("seq_busy_n1", busy_log[1], 1);
    check("seq_busy_n6", busy_log[6], 1);
    check("seq_busy_n8", busy_log[8], 0);
    check("seq_sunk", ballSunk, 8'h24);
`ifdef POCKET_SOUND_EN
    check("snd_n2", snd_log[2], 1);
    check("snd_n4", snd_log[4], 1);
    check("snd_n6", snd_log[6], 2);
`endif

    // White episodes: hit, hit, clear, hit -> two penalties
    new_game();
    dec_total = 0;
    frame(8'h01, 10); count_pulses(8, ni, nd, first); dec_total += nd;
    frame(8'h01, 10); count_pulses(8, ni, nd, first); dec_total += nd;
    check("white_cont_dec", nd, 0);
    frame(8'h00, 10); count_pulses(8, ni, nd, first); dec_total += nd;
    frame(8'h01, 10); count_pulses(8, ni, nd, first); dec_total += nd;
    check("white_total_dec", dec_total, 2);

    // Sink all coloured balls, then newGame on the final pulse
    new_game();
    for (int b = 1; b <= 7; b++) begin
      frame(8'(1 << b), 3);
      check($sformatf("all_after_%0d", b), allSunk, (b == 7) ? 1 : 0);
      if (b < 7) repeat (6) tick();
    end
    check("all_mask", ballSunk, 8'hFE);
    tick();
    check("final_pulse", increaseScore, 1);
`ifdef POCKET_SOUND_EN
    check("snd_win", soundSel, 3);
`endif
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    check("ng_final_inc", increaseScore, 0);
    check("ng_final_sunk", ballSunk, 0);
    check("ng_final_all", allSunk, 0);
    check("ng_final_busy", busy, 0);

    // newGame before the pulse leaves -> pulse dropped
    frame(8'h02, 3);
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    check("drop_inc", increaseScore, 0);
    count_pulses(6, ni, nd, first);
    check("drop_count", ni + nd, 0);

    // Mid-operation asynchronous reset
    frame(8'h10, 3);
    #2;
    resetN = 1'b0;
    #1;
    check("async_sunk", ballSunk, 0);
    check("async_busy", busy, 0);
    check("async_inc", increaseScore, 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    count_pulses(10, ni, nd, first);
    check("post_rst_pulses", ni + nd, 0);
    frame(8'h00, 2);
    count_pulses(6, ni, nd, first);
    check("post_rst_empty_frame", ni + nd, 0);

    check("no_overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
